// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues instruction-memory reads and buffers
// returned instructions (tagged with their PC) in a small prefetch queue for decode.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [15:0]                im_addr,
    output logic                       im_rd_en,
    input  logic [16:0]                im_instr,
    input  logic                       redirect,
    input  logic [15:0]                redirect_pc,
    input  logic                       halt,
    input  logic                       deq,
    output logic [16:0]                instr_out,
    output logic [15:0]                instr_pc,
    output logic                       instr_vld,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [15:0]   fetch_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    logic [16:0]   q_instr [DEPTH];
    logic [15:0]   q_pc    [DEPTH];

    // Decode handshake: instr_vld means the head entry is valid; decode asserts
    // deq in a cycle where instr_vld=1 to consume it on the next posedge.
    // deq while empty, or in a redirect cycle, is ignored.
    assign full     = (count == CW'(DEPTH));
    assign im_rd_en = (state == ST_FETCH) && !full && !redirect && !halt;
    assign push     = im_rd_en;
    assign pop      = deq && (count != '0) && !redirect;

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = halt ? ST_HALT : ST_FETCH;
            ST_FETCH: state_next = halt ? ST_HALT : ST_FETCH;
            ST_HALT:  state_next = halt ? ST_HALT : ST_FETCH;
            default:  state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                // Flush wins over any same-cycle dequeue; no push is possible here.
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + 16'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Memory data arrives on the negedge of the issue cycle, so it is stable here.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= im_instr;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign im_addr   = fetch_pc;
    assign instr_vld = (count != '0);
    assign instr_out = instr_vld ? q_instr[rd_ptr] : '0;
    assign instr_pc  = instr_vld ? q_pc[rd_ptr]    : '0;
    assign q_count   = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: instruction-memory model, negedge scoreboard of
// fetched entries, and per-scenario tasks checking addresses, handshake and flushes.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [16:0] im_instr = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        deq = 1'b0;
    logic [16:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_vld;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    int          sz;
    logic [32:0] head;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_rd_en(im_rd_en),
        .im_instr(im_instr), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .deq(deq), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_vld(instr_vld), .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] exp_instr(input logic [15:0] a);
        return {1'b0, a} + 17'h100;
    endfunction

    // Memory model: mem[k] = k + 0x100, updated on negedge when read is enabled.
    always @(negedge clk) begin
        if (im_rd_en) im_instr <= exp_instr(im_addr);
    end

    // Scoreboard: push on issue, pop on accepted deq, flush on redirect/reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            sz = exp_q.size();
            checks++;
            if (q_count !== 3'(sz) || instr_vld !== (sz != 0)) begin
                errors++;
                $display("FAIL sb_count: q_count=%0d vld=%0b, expected %0d", q_count, instr_vld, sz);
            end
            if (sz != 0) begin
                head = exp_q[0];
                checks++;
                if ({instr_out, instr_pc} !== head) begin
                    errors++;
                    $display("FAIL sb_head: got instr=%h pc=%h, expected instr=%h pc=%h",
                             instr_out, instr_pc, head[32:16], head[15:0]);
                end
                if (deq && !redirect) void'(exp_q.pop_front());
            end
            if (redirect) exp_q.delete();
            if (im_rd_en) begin
                if (sz == DEPTH) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_overfill: im_rd_en=1 with %0d entries queued", sz);
                end
                exp_q.push_back({exp_instr(im_addr), im_addr});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_issue(input string name, input logic en, input logic [15:0] addr);
        checks++;
        if (im_rd_en !== en || (en && im_addr !== addr)) begin
            errors++;
            $display("FAIL %s: rd_en=%0b addr=%h, expected rd_en=%0b addr=%h",
                     name, im_rd_en, im_addr, en, addr);
        end
    endtask

    task automatic test_reset();
        deq = 1'b0; halt = 1'b0; redirect = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (im_rd_en !== 1'b0 || instr_vld !== 1'b0 || q_count !== 3'd0 ||
            instr_out !== 17'h0 || instr_pc !== 16'h0 || im_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_state: rd_en=%0b vld=%0b cnt=%0d out=%h pc=%h addr=%h, expected all 0/RESET_PC",
                     im_rd_en, instr_vld, q_count, instr_out, instr_pc, im_addr);
        end
    endtask

    task automatic test_stream();
        deq = 1'b1;
        do_reset();
        @(negedge clk);
        chk_issue("boot_no_fetch", 1'b0, 16'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_issue("stream_addr", 1'b1, 16'(i));
            if (i >= 1) begin
                checks++;
                if (instr_vld !== 1'b1 || instr_pc !== 16'(i - 1) || instr_out !== exp_instr(16'(i - 1))) begin
                    errors++;
                    $display("FAIL stream_head: vld=%0b pc=%h out=%h, expected pc=%h out=%h",
                             instr_vld, instr_pc, instr_out, 16'(i - 1), exp_instr(16'(i - 1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        deq = 1'b0;
        do_reset();
        @(negedge clk);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_issue("fill_addr", 1'b1, 16'(i));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_issue("full_stall", 1'b0, 16'h0);
            checks++;
            if (q_count !== 3'd4) begin
                errors++;
                $display("FAIL full_count: q_count=%0d, expected 4", q_count);
            end
            tick();
        end
        deq = 1'b1;
        @(negedge clk);
        chk_issue("full_deq_no_issue", 1'b0, 16'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_issue("drain_resume", 1'b1, 16'(4 + i));
            checks++;
            if (instr_out !== exp_instr(16'(i + 1))) begin
                errors++;
                $display("FAIL drain_order: out=%h, expected %h", instr_out, exp_instr(16'(i + 1)));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        deq = 1'b0;
        do_reset();
        @(negedge clk);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick();
        end
        redirect = 1'b1; redirect_pc = 16'h0040; deq = 1'b1;
        @(negedge clk);
        chk_issue("redirect_no_issue", 1'b0, 16'h0);
        checks++;
        if (q_count !== 3'd3) begin
            errors++;
            $display("FAIL redirect_pre_count: q_count=%0d, expected 3", q_count);
        end
        tick();
        redirect = 1'b0; deq = 1'b0;
        @(negedge clk);
        checks++;
        if (q_count !== 3'd0 || instr_vld !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: q_count=%0d vld=%0b, expected 0/0", q_count, instr_vld);
        end
        chk_issue("redirect_target", 1'b1, 16'h0040);
        tick();
        @(negedge clk);
        checks++;
        if (instr_vld !== 1'b1 || instr_out !== 17'h140 || instr_pc !== 16'h0040) begin
            errors++;
            $display("FAIL redirect_head: vld=%0b out=%h pc=%h, expected 1/00140/0040",
                     instr_vld, instr_out, instr_pc);
        end
        tick();
    endtask

    task automatic test_halt();
        int halt_cnt[5] = '{2, 1, 0, 0, 0};
        deq = 1'b0;
        do_reset();
        @(negedge clk);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tick();
        end
        halt = 1'b1; deq = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin redirect = 1'b1; redirect_pc = 16'h0010; end
            if (k == 3) redirect = 1'b0;
            @(negedge clk);
            chk_issue("halt_no_issue", 1'b0, 16'h0);
            checks++;
            if (q_count !== 3'(halt_cnt[k])) begin
                errors++;
                $display("FAIL halt_drain: q_count=%0d, expected %0d", q_count, halt_cnt[k]);
            end
            tick();
        end
        halt = 1'b0;
        @(negedge clk);
        chk_issue("halt_exit_bubble", 1'b0, 16'h0);
        tick();
        @(negedge clk);
        chk_issue("halt_redirect_target", 1'b1, 16'h0010);
        tick();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a;
        deq = 1'b1;
        do_reset();
        @(negedge clk);
        tick();
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        @(negedge clk);
        tick();
        redirect = 1'b0;
        exp_a = 16'hFFFE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) chk_issue("wrap_addr", 1'b1, exp_a);
            if (i >= 1) begin
                checks++;
                if (instr_pc !== exp_a - 16'd1) begin
                    errors++;
                    $display("FAIL wrap_tag: pc=%h, expected %h", instr_pc, exp_a - 16'd1);
                end
            end
            exp_a = exp_a + 16'd1;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        deq = 1'b0;
        do_reset();
        @(negedge clk);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        checks++;
        if (q_count !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre_count: q_count=%0d, expected 3", q_count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_vld !== 1'b0 || q_count !== 3'd0 || im_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: vld=%0b cnt=%0d rd_en=%0b, expected 0/0/0",
                     instr_vld, q_count, im_rd_en);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        deq = 1'b1;
        @(negedge clk);
        chk_issue("mid_boot", 1'b0, 16'h0);
        tick();
        @(negedge clk);
        chk_issue("mid_restart", 1'b1, RESET_PC);
        tick();
        @(negedge clk);
        checks++;
        if (instr_vld !== 1'b1 || instr_pc !== RESET_PC || instr_out !== exp_instr(RESET_PC)) begin
            errors++;
            $display("FAIL mid_restart_head: vld=%0b pc=%h out=%h, expected 1/%h/%h",
                     instr_vld, instr_pc, instr_out, RESET_PC, exp_instr(RESET_PC));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the 17-bit instruction memory.
- Owns the fetch PC and drives the memory address and read enable.
- Captures each returned 17-bit instruction into a small prefetch queue, tagged with its PC, and presents the queue head to decode with a valid/dequeue handshake.
- Accepts a branch/jump redirect that flushes the queue and restarts fetch, and a halt that freezes fetch while the queue drains.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- im_addr  output  16  instruction memory address; always equals fetch_pc.
- im_rd_en  output  1  instruction memory read enable.
- im_instr  input  17  instruction memory read data; updated by memory on negedge when im_rd_en=1.
- redirect  input  1  PC redirect strobe from execute.
- redirect_pc  input  16  redirect target address.
- halt  input  1  level; stop issuing fetches.
- deq  input  1  decode consumes queue head this cycle.
- instr_out  output  17  queue head instruction.
- instr_pc  output  16  PC of queue head.
- instr_vld  output  1  queue non-empty.
- q_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - state=BOOT, fetch_pc=RESET_PC, queue count=0, rd/wr pointers=0.
  - im_rd_en=0, instr_vld=0, q_count=0.
  - instr_out and instr_pc read as 0 while empty.
  - Reset mid-operation discards all queued entries immediately.
- States:
  - BOOT:
    - Exactly one cycle after rst_n rises; no fetch issued.
    - Goes to HALT if halt=1, otherwise to FETCH.
    - A redirect during BOOT loads redirect_pc and is still honoured.
  - FETCH:
    - Issues reads.
    - Goes to HALT on halt=1, sampled at the posedge.
  - HALT:
    - No reads issued.
    - Goes to FETCH when halt=0.
- Issue rule: im_rd_en = (state==FETCH) && (count<DEPTH) && !redirect && !halt. Combinational from registered state plus redirect and halt.
- Fetch timing:
  - Cycle N: im_addr=fetch_pc and im_rd_en=1.
  - The memory updates im_instr on the negedge inside cycle N.
  - On the posedge ending cycle N, {im_instr, fetch_pc} is pushed into the queue and fetch_pc increments by 1.
  - Effective latency is 1 cycle from issue to instr_vld.
- Full queue:
  - No issue when count==DEPTH, even if deq=1 that cycle.
  - Issue resumes the following cycle; one bubble per full-to-drain transition is acceptable.
- PC arithmetic: 16-bit unsigned; 16'hFFFF increments to 16'h0000.
- Dequeue:
  - On posedge with deq=1 and count>0, the head is popped.
  - deq with count==0 is ignored; no underflow and no pointer change.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (posedge with redirect=1):
  - Queue flushed: count=0 and pointers reset.
  - fetch_pc=redirect_pc.
  - No push that cycle, because im_rd_en is held low.
  - A simultaneous deq is ignored, since flush wins.
  - State is unchanged, except that BOOT still advances.
  - First fetch from redirect_pc occurs in the next FETCH cycle.
- Redirect while halted: fetch_pc and flush take effect; fetch stays stopped until halt=0.
- Outputs:
  - instr_out and instr_pc are the head entry, read combinationally from queue storage.
  - instr_vld = (count!=0).
  - q_count = count.

Test Plan:
- Reset release, halt=0, deq=1 continuous, memory preloaded mem[k]=k+17'h100:
  - im_rd_en=0 in the BOOT cycle.
  - From the next cycle, im_addr goes 0,1,2,…
  - instr_vld is high one cycle after the first issue, with instr_out=17'h100 and instr_pc=0, then one instruction per cycle.
- deq=0 held:
  - Exactly 4 reads issue (addr 0..3), then im_rd_en=0 and q_count=4.
  - Raising deq drains 0x100..0x103 in order; fetch resumes at addr 4.
- Redirect with 3 entries queued, redirect_pc=16'h0040, deq=1 in the same cycle:
  - Next cycle q_count=0 and instr_vld=0.
  - The following issue uses im_addr=16'h0040.
  - Head becomes 17'h140 with instr_pc=16'h0040.
- halt=1 for 5 cycles with 2 entries queued and deq=1:
  - im_rd_en=0 throughout; queue drains to empty and deq on empty causes no underflow (q_count stays 0).
  - A redirect to 16'h0010 mid-halt sets the next fetch to 16'h0010 after halt drops.
- Redirect to 16'hFFFE, free-running:
  - im_addr sequence is FFFE, FFFF, 0000, 0001, with instr_pc tags matching.
- rst_n pulsed low mid-stream with 3 entries queued:
  - instr_vld=0, q_count=0 and im_rd_en=0 immediately, without waiting for a clock edge.
  - After release, the fetch sequence restarts at RESET_PC following the BOOT cycle.
